// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the sequential ALU.
//   alu_op_e     - 5-bit opcode encodings (bit 4 selects the multiply/divide group)
//   alu_state_e  - control FSM states
//   is_mdu_op    - opcode belongs to the multiply/divide group
//   is_signed_op - opcode treats its operands as two's complement (MULH, DIV, REM)
//   is_div_op    - opcode is one of DIV/DIVU/REM/REMU
package alu_pkg;

  typedef enum logic [4:0] {
    OP_AND   = 5'b00000,
    OP_OR    = 5'b00001,
    OP_ADD   = 5'b00010,
    OP_SUB   = 5'b00011,
    OP_SLL   = 5'b00100,
    OP_SRL   = 5'b00101,
    OP_SRA   = 5'b00110,
    OP_EQ    = 5'b01000,
    OP_XOR   = 5'b01001,
    OP_SLT   = 5'b01100,
    OP_SLTU  = 5'b01101,
    OP_MUL   = 5'b10000,
    OP_MULH  = 5'b10001,
    OP_MULHU = 5'b10011,
    OP_DIV   = 5'b10100,
    OP_DIVU  = 5'b10101,
    OP_REM   = 5'b10110,
    OP_REMU  = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_mdu_op(input logic [4:0] op);
    case (op)
      OP_MUL, OP_MULH, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return is_mdu_op(op) && op[2];
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bus of the sequential ALU.
//   master: drives in_valid, SrcA, SrcB, Operation, out_ready
//   slave : drives in_ready, out_valid, ALUResult, busy
interface seq_alu_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    ALUResult;
  logic                     busy;

  modport master (
    output in_valid, SrcA, SrcB, Operation, out_ready,
    input  in_ready, out_valid, ALUResult, busy
  );

  modport slave (
    input  in_valid, SrcA, SrcB, Operation, out_ready,
    output in_ready, out_valid, ALUResult, busy
  );
endinterface

// File: rtl/seq_alu_mdu_iter.sv
// mdu_iter: iterative multiply/divide datapath, one bit per enabled step.
//   clk, rst_n - clock, async active-low reset
//   start      - load operands (magnitudes for signed ops) and clear the counter
//   op         - M-group opcode, captured on start
//   a, b       - operands, captured on start
//   step_en    - advance one shift-add / restoring-subtract bit
//   done       - current step is the last one; result is valid this cycle
//   result     - sign-corrected result of the final step
// hi/lo hold {partial product, multiplier} for MUL* and {remainder, quotient}
// for DIV*/REM*; b_q holds the multiplicand or divisor.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  step_en,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);
  localparam int W = DATA_WIDTH;

  logic [W-1:0]     hi_q, lo_q, b_q, hi_d, lo_d, mag_a, mag_b;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [4:0]       op_q;
  logic             neg_q, sgn_a, sgn_b;
  logic [W:0]       add_sum, rem_sh, trial;
  logic [2*W-1:0]   prod;

  always_comb begin
    sgn_a   = is_signed_op(op) & a[W-1];
    sgn_b   = is_signed_op(op) & b[W-1];
    mag_a   = sgn_a ? -a : a;
    mag_b   = sgn_b ? -b : b;

    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
    rem_sh  = {hi_q, lo_q[W-1]};
    trial   = rem_sh - {1'b0, b_q};

    if (op_q[2]) begin
      // Restoring divide: keep the difference only when it did not borrow.
      if (!trial[W]) begin
        hi_d = trial[W-1:0];
        lo_d = {lo_q[W-2:0], 1'b1};
      end else begin
        hi_d = rem_sh[W-1:0];
        lo_d = {lo_q[W-2:0], 1'b0};
      end
    end else begin
      hi_d = add_sum[W:1];
      lo_d = {add_sum[0], lo_q[W-1:1]};
    end

    prod = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    case (op_q)
      OP_MUL:              result = prod[W-1:0];
      OP_MULH, OP_MULHU:   result = prod[2*W-1:W];
      OP_DIV, OP_DIVU:     result = neg_q ? -lo_d : lo_d;
      OP_REM, OP_REMU:     result = neg_q ? -hi_d : hi_d;
      default:             result = '0;
    endcase

    done = step_en && (cnt_q == CNT_WIDTH'(W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
    end else if (start) begin
      op_q  <= op;
      // Remainder follows the dividend's sign; everything else takes sign(a)^sign(b).
      neg_q <= (op == OP_REM) ? sgn_a : (sgn_a ^ sgn_b);
      hi_q  <= '0;
      lo_q  <= mag_a;
      b_q   <= mag_b;
      cnt_q <= '0;
    end else if (step_en) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked integer ALU; base ops in one cycle, RV32M group iterative.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   flush - synchronous abort of any in-flight or held op
//   bus   - seq_alu_if.slave (in_valid/in_ready, SrcA, SrcB, Operation,
//           out_valid/out_ready, ALUResult, busy)
// Optional macro SEQ_ALU_FAST_MUL_EN: MUL/MULH/MULHU use a combinational
// product and complete in one cycle; divides always iterate.
//
// state  | meaning
// IDLE   | ready to accept a new op
// BUSY   | multiply/divide iterating in mdu_iter
// DONE   | ALUResult valid, waiting for out_ready
module seq_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5,
  parameter int CNT_WIDTH     = $clog2(DATA_WIDTH) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  seq_alu_if.slave   bus
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  alu_state_e   state_q;
  logic         in_ready_q, out_valid_q, busy_q;
  logic [W-1:0] result_q, single_res, a, b, mdu_result;
  logic [4:0]   op;
  logic [SW-1:0] shamt;
  logic         accept, div_zero, div_ovf, long_op, mdu_done;
`ifdef SEQ_ALU_FAST_MUL_EN
  logic [2*W-1:0] prod_ss, prod_uu;
`endif

  always_comb begin
    a        = bus.SrcA;
    b        = bus.SrcB;
    op       = bus.Operation[4:0];
    shamt    = b[SW-1:0];
    div_zero = is_div_op(op) && (b == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == '1);
`ifdef SEQ_ALU_FAST_MUL_EN
    prod_ss  = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    prod_uu  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    long_op  = is_div_op(op) && !div_zero && !div_ovf;
`else
    long_op  = is_mdu_op(op) && !div_zero && !div_ovf;
`endif
    single_res = '0;
    case (op)
      OP_AND:  single_res = a & b;
      OP_OR:   single_res = a | b;
      OP_ADD:  single_res = a + b;
      OP_SUB:  single_res = a - b;
      OP_SLL:  single_res = a << shamt;
      OP_SRL:  single_res = a >> shamt;
      OP_SRA:  single_res = $signed(a) >>> shamt;
      OP_EQ:   single_res = {{(W-1){1'b0}}, a == b};
      OP_XOR:  single_res = a ^ b;
      OP_SLT:  single_res = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: single_res = {{(W-1){1'b0}}, a < b};
`ifdef SEQ_ALU_FAST_MUL_EN
      OP_MUL:   single_res = prod_uu[W-1:0];
      OP_MULH:  single_res = prod_ss[2*W-1:W];
      OP_MULHU: single_res = prod_uu[2*W-1:W];
`endif
      // Only the divide special cases reach the register from here.
      OP_DIV, OP_DIVU: single_res = div_zero ? '1 : a;
      OP_REM, OP_REMU: single_res = div_zero ? a : '0;
      default: single_res = '0;
    endcase
  end

  assign accept = bus.in_valid & in_ready_q;

  mdu_iter #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_mdu (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && long_op && !flush),
    .op      (op),
    .a       (a),
    .b       (b),
    .step_en ((state_q == S_BUSY) && !flush),
    .done    (mdu_done),
    .result  (mdu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          if (long_op) begin
            state_q <= S_BUSY;
          end else begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= single_res;
          end
        end
        S_BUSY: if (mdu_done) begin
          state_q     <= S_DONE;
          out_valid_q <= 1'b1;
          result_q    <= mdu_result;
        end
        S_DONE: if (bus.out_ready) begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ALUResult = result_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.DATA_WIDTH(W), .OPCODE_LENGTH(5)) bus ();

  seq_alu #(.DATA_WIDTH(W), .OPCODE_LENGTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    longint       acc;
    int           lat;
    string        name;
  } exp_t;
  exp_t q[$];
  bit   seen = 1'b0;

  bit rand_ready  = 1'b0;
  bit force_ready = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model straight from the RISC-V arithmetic rules, using 64-bit math.
  function automatic logic [W-1:0] model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    int              sh = int'(b[4:0]);
    logic [W-1:0]    mn = 32'h8000_0000;
    case (int'(op))
      0:  return a & b;
      1:  return a | b;
      2:  return W'(ua + ub);
      3:  return W'(ua - ub);
      4:  return W'(ua * (64'd1 << sh));
      5:  return W'(ua / (64'd1 << sh));
      6:  return W'(sa >>> sh);
      8:  return (a == b) ? 1 : 0;
      9:  return a ^ b;
      12: return (sa < sb) ? 1 : 0;
      13: return (ua < ub) ? 1 : 0;
      16: return W'(ua * ub);
      17: return W'((sa * sb) >>> W);
      19: return W'((ua * ub) >> W);
      20: return (b == 0) ? '1 : ((a == mn && b == '1) ? a : W'(sa / sb));
      21: return (b == 0) ? '1 : W'(ua / ub);
      22: return (b == 0) ? a : ((a == mn && b == '1) ? '0 : W'(sa % sb));
      23: return (b == 0) ? a : W'(ua % ub);
      default: return '0;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int o = int'(op);
    bit is_mul = (o == 16) || (o == 17) || (o == 19);
    bit is_div = (o >= 20) && (o <= 23);
    if (is_div && (b == 0)) return 1;
    if ((o == 20 || o == 22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef SEQ_ALU_FAST_MUL_EN
    if (is_mul) return 1;
`else
    if (is_mul) return W + 1;
`endif
    if (is_div) return W + 1;
    return 1;
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic send(input string name, input logic [4:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input bit push);
    int n = 0;
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout %s: in_ready got 0 expected 1", name);
    end
    if (push) q.push_back('{model(op, a, b), cyc, model_lat(op, a, b), name});
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.SrcA      = $urandom;
    bus.SrcB      = $urandom;
    bus.Operation = 5'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending got %0d expected 0", q.size());
      q.delete();
      seen = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] sp[4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return W'($urandom_range(0, 20));
      2:       return -W'($urandom_range(1, 20));
      default: return sp[$urandom_range(0, 3)];
    endcase
  endfunction

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 (result %h)", bus.ALUResult);
      end else begin
        if (!seen) begin
          chk({"latency ", q[0].name}, 64'(cyc - q[0].acc), 64'(q[0].lat));
          seen = 1'b1;
        end
        chk({"result ", q[0].name}, 64'(bus.ALUResult), 64'(q[0].res));
        chk({"in_ready_low ", q[0].name}, 64'(bus.in_ready), 64'd0);
        chk({"busy_high ", q[0].name}, 64'(bus.busy), 64'd1);
        if (bus.out_ready) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #2;
    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
  end

  int ops[21] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 12, 13, 16, 17, 19, 20, 21, 22, 23, 7, 18, 31};

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.SrcA      = '0;
    bus.SrcB      = '0;
    bus.Operation = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset ALUResult", 64'(bus.ALUResult), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    send("ADD 5+7", 5'd2, 32'd5, 32'd7, 1);                         drain();
    send("SRA", 5'd6, 32'h8000_0000, 32'd4, 1);                     drain();
    send("MUL", 5'd16, 32'hFFFF_FFFF, 32'd2, 1);                    drain();
    send("MULHU", 5'd19, 32'hFFFF_FFFF, 32'd2, 1);                  drain();
    send("MULH", 5'd17, 32'hFFFF_FFFF, 32'd2, 1);                   drain();
    send("DIV -7/2", 5'd20, -32'd7, 32'd2, 1);                      drain();
    send("REM -7/2", 5'd22, -32'd7, 32'd2, 1);                      drain();
    send("DIVU 7/0", 5'd21, 32'd7, 32'd0, 1);                       drain();
    send("REMU 7/0", 5'd23, 32'd7, 32'd0, 1);                       drain();
    send("DIV ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 1);        drain();
    send("REM ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 1);        drain();
    send("SLT", 5'd12, -32'd1, 32'd1, 1);                           drain();
    send("SLTU", 5'd13, -32'd1, 32'd1, 1);                          drain();
    send("EQ", 5'd8, 32'h1234, 32'h1234, 1);                        drain();
    send("undef", 5'd7, 32'h55, 32'h66, 1);                         drain();
    send("MUL 3x4", 5'd16, 32'd3, 32'd4, 1);                        drain();

    // Backpressure: result and handshake held while out_ready is low
    force_ready = 1'b0;
    send("DIVU hold", 5'd21, 32'd1000, 32'd7, 1);
    n = 0;
    while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("hold reached", 64'(bus.out_valid), 64'd1);
    repeat (10) begin
      @(posedge clk); #1;
      chk("hold out_valid", 64'(bus.out_valid), 64'd1);
      chk("hold in_ready", 64'(bus.in_ready), 64'd0);
    end
    force_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("release in_ready", 64'(bus.in_ready), 64'd1);
    chk("release out_valid", 64'(bus.out_valid), 64'd0);
    drain();

    // Flush mid-iteration at counter 10
    send("DIVU flush", 5'd21, 32'hDEAD_BEEF, 32'd3, 0);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush busy", 64'(bus.busy), 64'd0);
    repeat (40) begin @(posedge clk); #1; end
    send("ADD 1+1", 5'd2, 32'd1, 32'd1, 1);                         drain();

    // Async reset mid-divide
    send("DIVU reset", 5'd21, 32'd100, 32'd7, 0);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst ALUResult", 64'(bus.ALUResult), 64'd0);
    chk("rst busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [4:0]   op = 5'(ops[$urandom_range(0, 20)]);
      logic [W-1:0] a  = rnd_operand();
      logic [W-1:0] b  = rnd_operand();
      send($sformatf("rnd%0d op%0d %h %h", i, op, a, b), op, a, b, 1);
      drain();
    end
    rand_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
